// File: rtl/relu_stream_sequencer.sv
// Sequences one activation pass: reads a vector from the activation buffer, routes each word
// through the external ReLU (or a sign-extending bypass) and streams the results out through a
// 2-entry FIFO that absorbs downstream backpressure.
module relu_stream_sequencer #(
  parameter int unsigned IN_WIDTH  = 8,
  parameter int unsigned OUT_WIDTH = 8,
  parameter int unsigned ADDR_W    = 10,
  parameter int unsigned LEN_W     = 11
) (
  input  logic                 clk_i,
  input  logic                 rst_ni,
  input  logic                 start_i,
  input  logic [LEN_W-1:0]     length_i,
  input  logic [ADDR_W-1:0]    base_addr_i,
  input  logic                 relu_mode_i,
  output logic                 busy_o,
  output logic                 done_o,
  output logic                 rd_en_o,
  output logic [ADDR_W-1:0]    rd_addr_o,
  input  logic [IN_WIDTH-1:0]  rd_data_i,
  output logic [IN_WIDTH-1:0]  relu_in_o,
  output logic                 relu_en_o,
  input  logic [OUT_WIDTH-1:0] relu_out_i,
  output logic                 out_valid_o,
  output logic [OUT_WIDTH-1:0] out_data_o,
  output logic                 out_last_o,
  input  logic                 out_ready_i
);

  typedef enum logic [1:0] {StIdle, StRun, StFlush, StDone} state_e;

  state_e               state_q;
  logic                 busy_q, done_q;
  logic [LEN_W-1:0]     length_q, issued_q;
  logic [ADDR_W-1:0]    base_q;
  logic                 mode_q;
  logic                 pend_q, pend_last_q;  // read in flight: rd_data_i valid this cycle

  logic [OUT_WIDTH:0]   fifo_q [2];           // {last, data}
  logic                 wr_ptr_q, rd_ptr_q;
  logic [1:0]           cnt_q;

  logic                 pop, push;
  logic [2:0]           occ_after;
  logic [OUT_WIDTH-1:0] bypass_ext, push_data;
  logic [OUT_WIDTH:0]   head;

  assign pop  = out_valid_o & out_ready_i;
  assign push = pend_q;

  // Credit check: words that will sit in the FIFO after this cycle plus the read landing now.
  assign occ_after = {1'b0, cnt_q} + {2'b00, pend_q} - {2'b00, pop};

  // Issue a read whenever words remain and the FIFO is guaranteed room for the returned word.
  always_comb begin
    rd_en_o = (state_q == StRun) && (issued_q != length_q) && (occ_after < 3'd2);
  end

  assign rd_addr_o  = base_q + ADDR_W'(issued_q);
  assign bypass_ext = OUT_WIDTH'($signed(rd_data_i));
  assign push_data  = mode_q ? relu_out_i : bypass_ext;
  assign relu_in_o  = pend_q ? rd_data_i : '0;
  assign relu_en_o  = busy_q & mode_q;
  assign busy_o     = busy_q;
  assign done_o     = done_q;

  assign head        = fifo_q[rd_ptr_q];
  assign out_valid_o = (cnt_q != 2'd0);
  assign out_data_o  = out_valid_o ? head[OUT_WIDTH-1:0] : '0;
  assign out_last_o  = out_valid_o & head[OUT_WIDTH];

  // Control FSM: command latch, read counter, in-flight tracking and registered busy/done.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q     <= StIdle;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      length_q    <= '0;
      issued_q    <= '0;
      base_q      <= '0;
      mode_q      <= 1'b0;
      pend_q      <= 1'b0;
      pend_last_q <= 1'b0;
    end else begin
      pend_q      <= rd_en_o;
      pend_last_q <= rd_en_o && (issued_q == length_q - LEN_W'(1));
      if (rd_en_o) begin
        issued_q <= issued_q + LEN_W'(1);
      end
      unique case (state_q)
        StIdle: begin
          done_q <= 1'b0;
          if (start_i) begin
            length_q <= length_i;
            base_q   <= base_addr_i;
            mode_q   <= relu_mode_i;
            issued_q <= '0;
            busy_q   <= 1'b1;
            // An empty pass skips reading and completes through the flush check.
            state_q  <= (length_i == '0) ? StFlush : StRun;
          end
        end
        StRun: begin
          if (rd_en_o && (issued_q + LEN_W'(1) == length_q)) begin
            state_q <= StFlush;
          end
        end
        StFlush: begin
          if ((length_q == '0) || (pop && out_last_o)) begin
            state_q <= StDone;
            busy_q  <= 1'b0;
            done_q  <= 1'b1;
          end
        end
        StDone: begin
          done_q  <= 1'b0;
          state_q <= StIdle;
        end
        default: state_q <= StIdle;
      endcase
    end
  end

  // Output FIFO: captures the read word one cycle after rd_en, pops on handshake.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      fifo_q[0] <= '0;
      fifo_q[1] <= '0;
      wr_ptr_q  <= 1'b0;
      rd_ptr_q  <= 1'b0;
      cnt_q     <= 2'd0;
    end else begin
      if (push) begin
        fifo_q[wr_ptr_q] <= {pend_last_q, push_data};
        wr_ptr_q         <= ~wr_ptr_q;
      end
      if (pop) begin
        rd_ptr_q <= ~rd_ptr_q;
      end
      unique case ({push, pop})
        2'b10:   cnt_q <= cnt_q + 2'd1;
        2'b01:   cnt_q <= cnt_q - 2'd1;
        default: cnt_q <= cnt_q;
      endcase
    end
  end

endmodule
